// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Bundles the imem, redirect and decode-side signals of fetch_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misalign;
    logic [31:0] pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        output misalign, pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        input  misalign, pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction-fetch sequencer with redirect squash.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire         clk,
    input  wire         rst,
    fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        misalign_d    = 1'b0;

        if (bus.redirect_valid) begin
            pc_d          = {bus.redirect_pc[31:2], 2'b00};
            instr_valid_d = 1'b0;
            misalign_d    = |bus.redirect_pc[1:0];
            // An accepted-but-unanswered old request must be drained in DISCARD.
            case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = bus.imem_ready  ? DISCARD : REQ;
                WAIT:    state_d = bus.imem_rvalid ? REQ : DISCARD;
                HOLD:    state_d = REQ;
                DISCARD: state_d = bus.imem_rvalid ? REQ : DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (bus.imem_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        pc_d          = pc_q + 32'd4;
                        state_d       = REQ;
                    end
                end
                DISCARD: begin
                    if (bus.imem_rvalid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.misalign    = misalign_q;
    assign bus.pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
    endtask

    // Zero-wait fetch of one word starting in REQ at addr; ends back in REQ.
    task automatic free_fetch(input logic [31:0] addr);
        logic [31:0] data;
        logic [31:0] nxt;
        data = addr ^ 32'hA5A5_0000;
        nxt  = addr + 32'd4;
        chk("ff_req", {31'h0, bus.imem_req}, 32'd1);
        chk("ff_addr", bus.imem_addr, addr);
        bus.imem_ready = 1'b1;
        step();
        chk("ff_wait_req", {31'h0, bus.imem_req}, 32'd0);
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        step();
        chk("ff_iv", {31'h0, bus.instr_valid}, 32'd1);
        chk("ff_instr", bus.instr, data);
        chk("ff_ipc", bus.instr_pc, addr);
        bus.imem_rvalid = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        chk("ff_iv_clr", {31'h0, bus.instr_valid}, 32'd0);
        chk("ff_pc_inc", bus.pc, nxt);
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();

        // Reset
        step();
        step();
        chk("rst_req", {31'h0, bus.imem_req}, 32'd0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_iv", {31'h0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_ipc", bus.instr_pc, 32'h0);
        chk("rst_mis", {31'h0, bus.misalign}, 32'd0);

        // Free-run: first request one cycle after release, 3 cycles per word
        rst = 1'b1;
        step();
        free_fetch(32'h0);
        free_fetch(32'h4);
        free_fetch(32'h8);
        free_fetch(32'hC);

        // Memory backpressure at 0x10
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_req", {31'h0, bus.imem_req}, 32'd1);
            chk("bp_addr", bus.imem_addr, 32'h10);
        end
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFE_0010;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        // Decode backpressure
        for (int i = 0; i < 5; i++) begin
            step();
            chk("dbp_iv", {31'h0, bus.instr_valid}, 32'd1);
            chk("dbp_instr", bus.instr, 32'hCAFE_0010);
            chk("dbp_pc", bus.pc, 32'h10);
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("dbp_pc_inc", bus.pc, 32'h14);
        chk("dbp_iv_clr", {31'h0, bus.instr_valid}, 32'd0);

        free_fetch(32'h14);
        free_fetch(32'h18);
        free_fetch(32'h1C);

        // Redirect while waiting on 0x20
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        clear_inputs();
        chk("rw_pc", bus.pc, 32'h100);
        chk("rw_req", {31'h0, bus.imem_req}, 32'd0);
        step();
        chk("rw_req2", {31'h0, bus.imem_req}, 32'd0);
        step();
        chk("rw_req3", {31'h0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_0020;
        step();
        bus.imem_rvalid = 1'b0;
        chk("rw_drop_iv", {31'h0, bus.instr_valid}, 32'd0);
        free_fetch(32'h100);

        // Redirect coincident with acceptance in REQ
        bus.imem_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        clear_inputs();
        chk("ra_pc", bus.pc, 32'h200);
        chk("ra_req", {31'h0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_0104;
        step();
        bus.imem_rvalid = 1'b0;
        chk("ra_req2", {31'h0, bus.imem_req}, 32'd1);
        chk("ra_addr", bus.imem_addr, 32'h200);
        chk("ra_iv", {31'h0, bus.instr_valid}, 32'd0);

        // Redirect coincident with rvalid in WAIT
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = 32'hDEAD_0200;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        step();
        clear_inputs();
        chk("rv_req", {31'h0, bus.imem_req}, 32'd1);
        chk("rv_addr", bus.imem_addr, 32'h300);
        chk("rv_iv", {31'h0, bus.instr_valid}, 32'd0);

        // Redirect coincident with instr_ready in HOLD
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_0300;
        step();
        bus.imem_rvalid = 1'b0;
        chk("rh_ipc", bus.instr_pc, 32'h300);
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        step();
        clear_inputs();
        chk("rh_pc", bus.pc, 32'h400);
        chk("rh_iv", {31'h0, bus.instr_valid}, 32'd0);
        chk("rh_req", {31'h0, bus.imem_req}, 32'd1);

        // Misaligned redirect while REQ is stalled
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0207;
        step();
        clear_inputs();
        chk("mis_pc", bus.pc, 32'h204);
        chk("mis_addr", bus.imem_addr, 32'h204);
        chk("mis_pulse", {31'h0, bus.misalign}, 32'd1);
        step();
        chk("mis_clr", {31'h0, bus.misalign}, 32'd0);
        chk("mis_req", {31'h0, bus.imem_req}, 32'd1);

        // Wrap from the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        chk("wr_pc", bus.pc, 32'hFFFF_FFFC);
        chk("wr_mis", {31'h0, bus.misalign}, 32'd0);
        free_fetch(32'hFFFF_FFFC);
        chk("wr_addr0", bus.imem_addr, 32'h0);

        // Reset asserted mid-WAIT with stray responses around it
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready  = 1'b0;
        rst             = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_0000;
        step();
        chk("mr_iv", {31'h0, bus.instr_valid}, 32'd0);
        chk("mr_pc", bus.pc, 32'h0);
        chk("mr_req", {31'h0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b0;
        step();
        rst             = 1'b1;
        bus.imem_rvalid = 1'b1;
        step();
        chk("mr_req2", {31'h0, bus.imem_req}, 32'd1);
        chk("mr_iv2", {31'h0, bus.instr_valid}, 32'd0);
        step();
        bus.imem_rvalid = 1'b0;
        chk("mr_req3", {31'h0, bus.imem_req}, 32'd1);
        chk("mr_iv3", {31'h0, bus.instr_valid}, 32'd0);
        free_fetch(32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
